display_scan_ctrl: RTL and testbench

- Sequencing controller for the 4-digit multiplexed seven-segment display that shows the CPU output register.
- Accepts an 8-bit value from the bus on a load strobe and converts it to BCD with a sequential double-dabble engine, optionally as two's-complement.
- Time-multiplexes the four digits with a programmable refresh period and drives active-low anodes and segments.
- Runs entirely in the sys_clk domain; the load strobe must already be synchronous to sys_clk.

---
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bus-side and display-side signals of the seven-segment scan controller.
// The master drives load, bus and enable; the slave returns status and the display drive.
interface display_scan_ctrl_if;
    logic       enable;
    logic       load;
    logic       signed_mode;
    logic [7:0] bus;
    logic       busy;
    logic [7:0] segments;
    logic [3:0] digit;

    modport master (
        output enable, load, signed_mode, bus,
        input  busy, segments, digit
    );

    modport slave (
        input  enable, load, signed_mode, bus,
        output busy, segments, digit
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed seven-segment controller: sequential double-dabble BCD conversion
// of an 8-bit (optionally signed) value, with a refresh scan and active-low outputs.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic                sys_clk,
    input logic                rst,
    display_scan_ctrl_if.slave io
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e          state_q, state_d;
    logic [2:0]      iter_q, iter_d;
    logic [11:0]     bcd_q, bcd_d;
    logic [7:0]      sreg_q, sreg_d;
    logic            neg_cv_q, neg_cv_d;
    logic [3:0]      hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic            neg_q, neg_d;
    logic [CntW-1:0] rcnt_q, rcnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      dig_q, dig_d;

    logic        accept, shift_en, commit;
    logic        neg_in;
    logic [11:0] adj;
    logic        wrap;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Converter FSM: state register
    always_ff @(posedge sys_clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Converter FSM: next state. A load arriving on the commit edge starts the next conversion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (io.load) state_d = StShift;
            StShift:  if (iter_q == 3'd7) state_d = StCommit;
            StCommit: state_d = io.load ? StShift : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Converter FSM: outputs
    always_comb begin
        accept   = io.load && (state_q != StShift);
        shift_en = (state_q == StShift);
        commit   = (state_q == StCommit);
        io.busy  = (state_q != StIdle);
    end

    always_comb begin
        iter_d   = iter_q;
        bcd_d    = bcd_q;
        sreg_d   = sreg_q;
        neg_cv_d = neg_cv_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        neg_d    = neg_q;
        neg_in   = io.signed_mode & io.bus[7];
        adj      = bcd_q;

        // Shadow registers change only here, so the scan never sees a partial result.
        if (commit) begin
            {hund_d, tens_d, ones_d} = bcd_q;
            neg_d                    = neg_cv_q;
        end

        if (accept) begin
            neg_cv_d = neg_in;
            sreg_d   = neg_in ? (~io.bus + 8'd1) : io.bus;
            bcd_d    = '0;
            iter_d   = '0;
        end else if (shift_en) begin
            for (int i = 0; i < 3; i++) begin
                if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
            {bcd_d, sreg_d} = {adj[10:0], sreg_q, 1'b0};
            iter_d          = iter_q + 3'd1;
        end
    end

    // Refresh scan and registered display drive
    always_comb begin
        wrap   = (rcnt_q == CntW'(REFRESH_DIV - 1));
        rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;

        seg_d = 8'hFF;
        dig_d = 4'b1111;
        if (io.enable) begin
            dig_d = ~(4'b0001 << idx_q);
            unique case (idx_q)
                2'd0: seg_d = seg_code(ones_q);
                2'd1: seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? 8'hFF : seg_code(tens_q);
                2'd2: seg_d = (hund_q == 4'd0) ? 8'hFF : seg_code(hund_q);
                2'd3: seg_d = neg_q ? 8'hBF : 8'hFF;
                default: seg_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            iter_q   <= '0;
            bcd_q    <= '0;
            sreg_q   <= '0;
            neg_cv_q <= 1'b0;
            hund_q   <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            neg_q    <= 1'b0;
            rcnt_q   <= '0;
            idx_q    <= '0;
            seg_q    <= 8'hFF;
            dig_q    <= 4'b1111;
        end else begin
            iter_q   <= iter_d;
            bcd_q    <= bcd_d;
            sreg_q   <= sreg_d;
            neg_cv_q <= neg_cv_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            neg_q    <= neg_d;
            rcnt_q   <= rcnt_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign io.segments = seg_q;
    assign io.digit    = dig_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random loads,
// compared against a decimal-arithmetic model of the displayed value and scan position.
module tb_display_scan_ctrl;
    localparam int unsigned Div = 4;

    logic sys_clk = 1'b0;
    logic rst;
    display_scan_ctrl_if dif ();

    display_scan_ctrl #(.REFRESH_DIV(Div)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .io      (dif)
    );

    always #5 sys_clk = ~sys_clk;

    // Non-reset edges since the last reset edge; drives the model scan position.
    int edges = 0;
    always @(posedge sys_clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    int checks = 0;
    int errors = 0;
    int exp_mag = 0;
    bit exp_neg = 1'b0;
    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic void set_model(input logic [7:0] val, input logic sm);
        if (sm && val >= 8'd128) begin
            exp_mag = 256 - int'(val);
            exp_neg = 1'b1;
        end else begin
            exp_mag = int'(val);
            exp_neg = 1'b0;
        end
    endfunction

    // Index shown by the registered outputs after `edges` edges (one edge of output latency).
    function automatic int exp_idx();
        return ((edges - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_dig(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    function automatic logic [7:0] exp_code(input int idx);
        case (idx)
            0:       return seg_tbl[exp_mag % 10];
            1:       return (exp_mag < 10) ? 8'hFF : seg_tbl[(exp_mag / 10) % 10];
            2:       return (exp_mag < 100) ? 8'hFF : seg_tbl[exp_mag / 100];
            default: return exp_neg ? 8'hBF : 8'hFF;
        endcase
    endfunction

    task automatic scan_check(input string name, input int cycles);
        int idx;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            idx = exp_idx();
            checks++;
            if (dif.digit !== exp_dig(idx) || dif.segments !== exp_code(idx)) begin
                errors++;
                $display("FAIL %s: got dig=%b seg=%h, expected dig=%b seg=%h (val=%0d neg=%0b)",
                         name, dif.digit, dif.segments, exp_dig(idx), exp_code(idx),
                         exp_mag, exp_neg);
            end
        end
    endtask

    // Pulses load across one edge and returns how many samples busy stayed high.
    task automatic do_load(input logic [7:0] val, input logic sm, output int busy_cycles);
        @(negedge sys_clk);
        dif.load        = 1'b1;
        dif.bus         = val;
        dif.signed_mode = sm;
        @(negedge sys_clk);
        dif.load = 1'b0;
        busy_cycles = 0;
        while (dif.busy === 1'b1 && busy_cycles < 30) begin
            busy_cycles++;
            @(negedge sys_clk);
        end
        set_model(val, sm);
    endtask

    task automatic load_and_check(input string name, input logic [7:0] val, input logic sm);
        int bc;
        do_load(val, sm, bc);
        checks++;
        if (bc != 9) begin
            errors++;
            $display("FAIL %s busy length: got %0d, expected 9", name, bc);
        end
        scan_check(name, 4 * Div + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            checks++;
            if (dif.busy !== 1'b0 || dif.segments !== 8'hFF || dif.digit !== 4'b1111) begin
                errors++;
                $display("FAIL reset: got busy=%b seg=%h dig=%b, expected 0/ff/1111",
                         dif.busy, dif.segments, dif.digit);
            end
        end
        rst = 1'b0;
        set_model(8'd0, 1'b0);
        scan_check("reset_scan", 5 * Div);
    endtask

    task automatic test_unsigned();
        load_and_check("unsigned_123", 8'd123, 1'b0);
    endtask

    task automatic test_signed();
        load_and_check("signed_80", 8'h80, 1'b1);
        load_and_check("signed_fb", 8'hFB, 1'b1);
        load_and_check("unsigned_fb", 8'hFB, 1'b0);
    endtask

    task automatic test_load_busy();
        @(negedge sys_clk);
        dif.load        = 1'b1;
        dif.bus         = 8'd255;
        dif.signed_mode = 1'b0;
        @(negedge sys_clk);
        dif.load = 1'b0;
        checks++;
        if (dif.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy start: got busy=%b, expected 1", dif.busy);
        end
        for (int c = 1; c < 12; c++) begin
            @(negedge sys_clk);
            checks++;
            if (dif.busy !== (c < 9)) begin
                errors++;
                $display("FAIL load_busy c=%0d: got busy=%b, expected %b", c, dif.busy, c < 9);
            end
            if (c == 2) begin
                dif.load = 1'b1;
                dif.bus  = 8'd7;
            end else begin
                dif.load = 1'b0;
            end
        end
        set_model(8'd255, 1'b0);
        scan_check("load_busy_255", 4 * Div + 1);
    endtask

    task automatic test_reset_mid();
        @(negedge sys_clk);
        dif.load        = 1'b1;
        dif.bus         = 8'd200;
        dif.signed_mode = 1'b0;
        @(negedge sys_clk);
        dif.load = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (dif.busy !== 1'b0 || dif.segments !== 8'hFF || dif.digit !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b seg=%h dig=%b, expected 0/ff/1111",
                     dif.busy, dif.segments, dif.digit);
        end
        rst = 1'b0;
        set_model(8'd0, 1'b0);
        scan_check("reset_mid_zero", 4 * Div + 1);
        load_and_check("after_reset_42", 8'd42, 1'b0);
    endtask

    task automatic test_enable();
        int w;
        w = 0;
        while (dif.digit !== 4'b1011 && w < 40) begin
            @(negedge sys_clk);
            w++;
        end
        checks++;
        if (dif.digit !== 4'b1011) begin
            errors++;
            $display("FAIL enable index2 wait: got dig=%b, expected 1011", dif.digit);
        end
        dif.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            checks++;
            if (dif.segments !== 8'hFF || dif.digit !== 4'b1111) begin
                errors++;
                $display("FAIL enable_off %0d: got seg=%h dig=%b, expected ff/1111",
                         i, dif.segments, dif.digit);
            end
        end
        dif.enable = 1'b1;
        scan_check("enable_resume", 3 * Div);
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       sm;
        for (int i = 0; i < 8; i++) begin
            v  = 8'($urandom_range(0, 255));
            sm = 1'($urandom_range(0, 1));
            load_and_check($sformatf("random_%0d", i), v, sm);
        end
    endtask

    initial begin
        rst             = 1'b1;
        dif.enable      = 1'b1;
        dif.load        = 1'b0;
        dif.signed_mode = 1'b0;
        dif.bus         = 8'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_load_busy();
        test_reset_mid();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
